// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Boot loader that receives an instruction image over a byte stream and writes
//   it into instruction memory one 32-bit word per cycle. It then fills the rest
//   of the memory with HALT_WORD and releases the core from reset.
//
//   Frame layout:
//     - word count N, 16-bit little-endian (2 bytes);
//     - 4*N instruction bytes, each word little-endian;
//     - with IMEM_LOADER_CHECKSUM_EN, one extra byte equal to the XOR of all
//       4*N data bytes.
//
//   A count of zero, or a count larger than DEPTH, sends the FSM to ERR. A
//   checksum mismatch also sends it to ERR. Words written before the check stay
//   written.
//
// Parameters:
//   DEPTH      instruction-memory depth in 32-bit words (must fit in 16 bits)
//   HALT_WORD  fill word written to every word past the image
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse; restarts a load from DONE or ERR
//   rx_valid   byte-stream valid
//   rx_data    byte-stream data
//   rx_ready   byte-stream ready (byte taken when rx_valid && rx_ready)
//   we         IMEM write strobe
//   waddr      IMEM byte address (word index << 2)
//   wdata      IMEM write data
//   cpu_rst_n  core reset, high only in DONE
//   done       high in DONE
//   error      high in ERR
//
// Optional feature:
//   IMEM_LOADER_CHECKSUM_EN  adds the CHK state and the XOR accumulator.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] HALT_WORD = 32'h00000063
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_CNT_LO = 3'd0;
  localparam logic [2:0] S_CNT_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_FILL   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(DEPTH - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic        accept;
  logic [15:0] n_new;
  logic [15:0] idx_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  // rx_ready depends on the state only, so no path exists from rx_valid to any output.
  assign rx_ready  = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CHK);
  assign we        = (state_q == S_WRITE) || (state_q == S_FILL);
  assign waddr     = {14'd0, idx_q, 2'b00};
  assign wdata     = (state_q == S_FILL) ? HALT_WORD : word_q;
  assign cpu_rst_n = (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);

  assign accept  = rx_valid && rx_ready;
  assign n_new   = {rx_data, count_q[7:0]};
  assign idx_inc = idx_q + 16'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif

    case (state_q)
      S_CNT_LO: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d = 8'd0;
`endif
        if (accept) begin
          count_d = {count_q[15:8], rx_data};
          state_d = S_CNT_HI;
        end
      end

      S_CNT_HI: begin
        if (accept) begin
          count_d = n_new;
          if ((n_new == 16'd0) || ({1'b0, n_new} > DEPTH_W)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          // Shift in from the top. After four bytes the first byte sits in [7:0].
          word_d = {rx_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          // A full-depth image has nothing to fill.
          state_d = (count_q == DEPTH_W[15:0]) ? S_DONE : S_FILL;
`endif
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (rx_data == xor_q) begin
            state_d = (count_q == DEPTH_W[15:0]) ? S_DONE : S_FILL;
          end else begin
            state_d = S_ERR;
          end
        end
      end
`endif

      S_FILL: begin
        idx_d = idx_inc;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end

      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_CNT_LO;
          idx_d   = 16'd0;
          count_d = 16'd0;
          bcnt_d  = 2'd0;
          word_d  = 32'd0;
        end
      end

      default: begin
        state_d = S_CNT_LO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CNT_LO;
      idx_q   <= 16'd0;
      count_q <= 16'd0;
      bcnt_q  <= 2'd0;
      word_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= 8'd0;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256: instruction-memory depth in 32-bit words.
REQ-002 Parameter HALT_WORD, default 32'h00000063: fill word (beq x0, x0, 0).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; restarts a load from DONE or ERR; ignored in other states.
REQ-006 rx_valid  input  1  byte-stream valid.
REQ-007 rx_data  input  8  byte-stream data.
REQ-008 rx_ready  output  1  byte-stream ready; byte accepted when rx_valid and rx_ready are both high.
REQ-009 we  output  1  IMEM write strobe, one cycle per word.
REQ-010 waddr  output  32  IMEM byte address, word-aligned (word index << 2), bits [1:0] = 0.
REQ-011 wdata  output  32  IMEM write data.
REQ-012 cpu_rst_n  output  1  core reset; low while loading, high only in DONE.
REQ-013 done  output  1  high in DONE.
REQ-014 error  output  1  high in ERR.

Function
REQ-015 States: CNT_LO, CNT_HI, DATA, WRITE, CHK (macro only), FILL, DONE, ERR.
REQ-016 Frame format: word count N as 16-bit little-endian (2 bytes), then 4*N instruction bytes, each word little-endian (first byte goes to wdata[7:0]).
REQ-017 rx_ready = 1 in CNT_LO, CNT_HI, DATA, CHK; 0 in all other states.
REQ-018 CNT_LO: accepted byte -> count[7:0], then CNT_HI. CNT_HI: accepted byte -> count[15:8], then DATA, unless N = 0 or N > DEPTH, in which case ERR.
REQ-019 DATA: the byte counter (2 bits) shifts each accepted byte into the assembly register; on the 4th byte, go to WRITE.
REQ-020 WRITE: we = 1 for exactly one cycle, with waddr = idx<<2 and wdata = assembled word; idx then increments.
REQ-021 After WRITE: if idx = N, go to FILL (or CHK with macro); otherwise return to DATA.
REQ-022 FILL: we = 1 every cycle with wdata = HALT_WORD and waddr = idx<<2 for idx = N .. DEPTH-1, then DONE; when N = DEPTH, FILL lasts zero write cycles and goes directly to DONE.
REQ-023 DONE, ERR: we = 0, rx_ready = 0; start -> CNT_LO with idx, count and byte counter cleared, and cpu_rst_n driven low on the next cycle.
REQ-024 All outputs are registered or decoded from state only; no combinational path from rx_valid/rx_data to any output.
REQ-025 rx_valid held low in any state: the FSM stalls with no writes; there is no timeout.
REQ-026 start during CNT_LO .. FILL has no effect.

Reset
REQ-027 rst_n low: state = CNT_LO, idx = 0, count = 0, byte counter = 0; outputs rx_ready = 1, we = 0, waddr = 0, wdata = 0, cpu_rst_n = 0, done = 0, error = 0.
REQ-028 Reset mid-load aborts the frame; partially assembled bytes are discarded and the next frame starts at CNT_LO.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN defined: after the last data word, CHK accepts one byte. If it equals the XOR of all 4*N data bytes, go to FILL; otherwise go to ERR (words already written stay written). The XOR accumulator is cleared in CNT_LO.
REQ-030 Macro undefined: CHK state and accumulator are absent; WRITE of the last word goes directly to FILL.

Verification
REQ-031 Frame 02 00, 13 00 10 00, 93 00 20 00, DEPTH=256 -> writes word 0 = 0x00100013 and word 1 = 0x00200093, then HALT at byte addresses 0x008..0x3FC (254 writes), then done = 1 and cpu_rst_n = 1.
REQ-032 Count bytes 00 00, or 01 01 (N = 257) -> error = 1, no we pulse, cpu_rst_n = 0; start then accepts a new valid frame.
REQ-033 N = 1 with rx_valid toggled randomly between bytes -> exactly one WRITE, wdata correct, no duplicated or dropped bytes.
REQ-034 rst_n asserted after 6 of the 8 data bytes, then a full new frame -> only the new frame's words are written, starting at waddr 0.
REQ-035 IMEM_LOADER_CHECKSUM_EN: frame 01 00, 13 00 10 00 followed by checksum 03 -> DONE; the same frame with checksum 04 -> ERR after word 0 is written, and no FILL writes occur.
REQ-036 N = DEPTH -> no FILL writes; done = 1 on the cycle after the last WRITE (or after CHK with the macro defined).
